// File: rtl/sqrt_pkg.sv
// Shared constants and FSM state type for the square-root BCD formatter.
package sqrt_pkg;

    // Width of each binary operand coming from the square-root core.
    localparam int W_IN        = 17;
    // BCD digits produced for the integer and fractional parts.
    localparam int INT_DIGITS  = 6;
    localparam int FRAC_DIGITS = 5;
    localparam int INT_W       = 4 * INT_DIGITS;
    localparam int FRAC_W      = 4 * FRAC_DIGITS;
    // Largest legal fractional value (units of 1e-5).
    localparam logic [W_IN-1:0] FRAC_MAX = 17'd99999;
    // One double-dabble iteration per input bit.
    localparam int ITER  = W_IN;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
    // Value reported for an out-of-range fraction.
    localparam logic [FRAC_W-1:0] FRAC_SAT = {FRAC_DIGITS{4'h9}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: every BCD digit >= 5 gets +3 so that the
// following left shift carries correctly into the next decade.
module bcd_add3 #(
    parameter int DIGITS = 1
) (
    input  logic [4*DIGITS-1:0] i_bcd,
    output logic [4*DIGITS-1:0] o_bcd
);

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi = gi + 1) begin : g_digit
            // Digits 5..9 become 8..12, which still fit in four bits.
            assign o_bcd[4*gi +: 4] = (i_bcd[4*gi +: 4] >= 4'd5) ?
                                      (i_bcd[4*gi +: 4] + 4'd3) :
                                      i_bcd[4*gi +: 4];
        end
    endgenerate

endmodule

// File: rtl/sqrt_bcd_formatter.sv
// Converts a square-root result (integer and 1e-5 fraction, both binary)
// into packed BCD using two parallel double-dabble converters. Fixed
// latency of ITER cycles from accept to out_valid_o; valid/ready on both sides.
module sqrt_bcd_formatter
    import sqrt_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [W_IN-1:0]     int_i,
    input  logic [W_IN-1:0]     frac_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [INT_W-1:0]    int_bcd_o,
    output logic [FRAC_W-1:0]   frac_bcd_o,
    output logic                ovf_o
);

    state_t              r_state,     w_state_next;
    logic [CNT_W-1:0]    r_cnt,       w_cnt_next;
    logic [W_IN-1:0]     r_int_sh,    w_int_sh_next;
    logic [W_IN-1:0]     r_frac_sh,   w_frac_sh_next;
    logic [INT_W-1:0]    r_int_acc,   w_int_acc_next;
    logic [FRAC_W-1:0]   r_frac_acc,  w_frac_acc_next;
    logic                r_ovf_pend,  w_ovf_pend_next;
    logic [INT_W-1:0]    r_int_bcd,   w_int_bcd_next;
    logic [FRAC_W-1:0]   r_frac_bcd,  w_frac_bcd_next;
    logic                r_ovf,       w_ovf_next;

    logic [INT_W-1:0]    w_int_acc_corr;
    logic [FRAC_W-1:0]   w_frac_acc_corr;
    logic [INT_W-1:0]    w_int_acc_shift;
    logic [FRAC_W-1:0]   w_frac_acc_shift;

    bcd_add3 #(.DIGITS(INT_DIGITS)) u_int_add3 (
        .i_bcd (r_int_acc),
        .o_bcd (w_int_acc_corr)
    );

    bcd_add3 #(.DIGITS(FRAC_DIGITS)) u_frac_add3 (
        .i_bcd (r_frac_acc),
        .o_bcd (w_frac_acc_corr)
    );

    // Corrected accumulator shifted left with the next binary MSB brought in.
    assign w_int_acc_shift  = (w_int_acc_corr << 1)  | INT_W'(r_int_sh[W_IN-1]);
    assign w_frac_acc_shift = (w_frac_acc_corr << 1) | FRAC_W'(r_frac_sh[W_IN-1]);

    assign in_ready_o  = (r_state == ST_IDLE);
    assign out_valid_o = (r_state == ST_DONE);
    assign int_bcd_o   = r_int_bcd;
    assign frac_bcd_o  = r_frac_bcd;
    assign ovf_o       = r_ovf;

    // Next-state and datapath: accept in IDLE, iterate in CONV, hold in DONE.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_int_sh_next   = r_int_sh;
        w_frac_sh_next  = r_frac_sh;
        w_int_acc_next  = r_int_acc;
        w_frac_acc_next = r_frac_acc;
        w_ovf_pend_next = r_ovf_pend;
        w_int_bcd_next  = r_int_bcd;
        w_frac_bcd_next = r_frac_bcd;
        w_ovf_next      = r_ovf;

        case (r_state)
            ST_IDLE: begin
                if (in_valid_i) begin
                    w_int_sh_next   = int_i;
                    w_frac_sh_next  = frac_i;
                    w_int_acc_next  = '0;
                    w_frac_acc_next = '0;
                    w_cnt_next      = '0;
                    w_ovf_pend_next = (frac_i > FRAC_MAX);
                    w_state_next    = ST_CONV;
                end
            end
            ST_CONV: begin
                w_int_acc_next  = w_int_acc_shift;
                w_frac_acc_next = w_frac_acc_shift;
                w_int_sh_next   = r_int_sh << 1;
                w_frac_sh_next  = r_frac_sh << 1;
                w_cnt_next      = r_cnt + 1'b1;
                // Last iteration: publish the freshly shifted accumulators.
                if (r_cnt == CNT_LAST) begin
                    w_int_bcd_next  = w_int_acc_shift;
                    w_frac_bcd_next = r_ovf_pend ? FRAC_SAT : w_frac_acc_shift;
                    w_ovf_next      = r_ovf_pend;
                    w_state_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // All state registers; reset clears everything including the outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_int_sh   <= '0;
            r_frac_sh  <= '0;
            r_int_acc  <= '0;
            r_frac_acc <= '0;
            r_ovf_pend <= 1'b0;
            r_int_bcd  <= '0;
            r_frac_bcd <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_int_sh   <= w_int_sh_next;
            r_frac_sh  <= w_frac_sh_next;
            r_int_acc  <= w_int_acc_next;
            r_frac_acc <= w_frac_acc_next;
            r_ovf_pend <= w_ovf_pend_next;
            r_int_bcd  <= w_int_bcd_next;
            r_frac_bcd <= w_frac_bcd_next;
            r_ovf      <= w_ovf_next;
        end
    end

endmodule

// File: tb/tb_sqrt_bcd_formatter.sv
// Scoreboard bench for sqrt_bcd_formatter: expected BCD is computed by
// decimal division when a result is offered and compared when it emerges.
module tb_sqrt_bcd_formatter;

    typedef struct {
        logic [23:0] int_bcd;
        logic [19:0] frac_bcd;
        logic        ovf;
    } exp_t;

    logic        clk_i;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [16:0] int_i;
    logic [16:0] frac_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [23:0] int_bcd_o;
    logic [19:0] frac_bcd_o;
    logic        ovf_o;

    exp_t sb[$];
    exp_t last_e;
    int   n_checks;
    int   n_pass;

    sqrt_bcd_formatter dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .int_i       (int_i),
        .frac_i      (frac_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .int_bcd_o   (int_bcd_o),
        .frac_bcd_o  (frac_bcd_o),
        .ovf_o       (ovf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    function automatic logic [23:0] to_bcd(input int v, input int digits);
        logic [23:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < digits; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        logic [23:0] fb;
        e.int_bcd = to_bcd(a, 6);
        e.ovf     = (b > 99999);
        fb        = to_bcd(b, 5);
        e.frac_bcd = e.ovf ? 20'h99999 : fb[19:0];
        return e;
    endfunction

    // Offer one result, wait for it, compare, optionally stall in DONE.
    task automatic run_txn(input int a, input int b, input int hold);
        exp_t e;
        int   cyc;
        logic got;
        @(negedge clk_i);
        chk("in_ready_idle", 64'(in_ready_o), 64'd1);
        int_i       = 17'(a);
        frac_i      = 17'(b);
        in_valid_i  = 1'b1;
        out_ready_i = (hold == 0);
        sb.push_back(model(a, b));
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (cyc < 40 && !got) begin
            if (cyc == 5) begin
                chk("in_ready_conv", 64'(in_ready_o), 64'd0);
                chk("int_hold_conv", 64'(int_bcd_o), 64'(last_e.int_bcd));
                chk("frac_hold_conv", 64'(frac_bcd_o), 64'(last_e.frac_bcd));
            end
            @(posedge clk_i); #1;
            cyc++;
            got = out_valid_o;
        end
        if (!got) begin
            chk("out_valid_timeout", 64'd0, 64'd1);
            void'(sb.pop_front());
            return;
        end
        chk("latency", 64'(cyc), 64'd17);
        e = sb.pop_front();
        chk("int_bcd", 64'(int_bcd_o), 64'(e.int_bcd));
        chk("frac_bcd", 64'(frac_bcd_o), 64'(e.frac_bcd));
        chk("ovf", 64'(ovf_o), 64'(e.ovf));
        chk("in_ready_done", 64'(in_ready_o), 64'd0);
        last_e = e;
        for (int h = 0; h < hold; h++) begin
            in_valid_i = 1'b1;
            int_i      = 17'h1ABCD;
            frac_i     = 17'h00123;
            @(posedge clk_i); #1;
            chk("stall_valid", 64'(out_valid_o), 64'd1);
            chk("stall_ready", 64'(in_ready_o), 64'd0);
            chk("stall_int", 64'(int_bcd_o), 64'(e.int_bcd));
            chk("stall_frac", 64'(frac_bcd_o), 64'(e.frac_bcd));
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("back_idle_ready", 64'(in_ready_o), 64'd1);
        chk("back_idle_valid", 64'(out_valid_o), 64'd0);
        chk("idle_int_keep", 64'(int_bcd_o), 64'(e.int_bcd));
        out_ready_i = 1'b0;
        $display("txn int=%0d frac=%0d hold=%0d -> int_bcd=%06h frac_bcd=%05h ovf=%0d lat=%0d",
                 a, b, hold, int_bcd_o, frac_bcd_o, ovf_o, cyc);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        int_i       = '0;
        frac_i      = '0;
        last_e.int_bcd  = '0;
        last_e.frac_bcd = '0;
        last_e.ovf      = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_int", 64'(int_bcd_o), 64'd0);
        chk("rst_frac", 64'(frac_bcd_o), 64'd0);
        chk("rst_ovf", 64'(ovf_o), 64'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        run_txn(92681, 96875, 0);
        run_txn(0, 0, 0);
        run_txn(131071, 3125, 0);
        run_txn(5, 120000, 0);
        run_txn(77, 99999, 5);
        run_txn(123456, 100000, 0);
        for (int k = 0; k < 4; k++) begin
            run_txn(int'($urandom_range(0, 131071)), int'($urandom_range(0, 99999)), k % 2);
        end

        // Reset in the middle of a conversion, after eight iterations.
        @(negedge clk_i);
        int_i      = 17'd1000;
        frac_i     = 17'd2000;
        in_valid_i = 1'b1;
        sb.push_back(model(1000, 2000));
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        repeat (8) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("midrst_in_ready", 64'(in_ready_o), 64'd1);
        chk("midrst_out_valid", 64'(out_valid_o), 64'd0);
        chk("midrst_int", 64'(int_bcd_o), 64'd0);
        chk("midrst_frac", 64'(frac_bcd_o), 64'd0);
        chk("midrst_ovf", 64'(ovf_o), 64'd0);
        $display("txn reset pulsed at iteration 8 -> int_bcd=%06h frac_bcd=%05h ovf=%0d",
                 int_bcd_o, frac_bcd_o, ovf_o);
        last_e.int_bcd  = '0;
        last_e.frac_bcd = '0;
        last_e.ovf      = 1'b0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        run_txn(4, 50000, 0);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
